// File: rtl/operand_feeder.sv
// Operand feeder: queues (a,b) pairs in a small FIFO and sequences them one at
// a time through a level-handshake y = a^2 + b^(1/3) engine, holding each
// result (with its operands and engine latency) until the consumer takes it.

package operand_feeder_pkg;

  // One queued operand pair.
  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
  } pair_t;

endpackage

module operand_feeder
  import operand_feeder_pkg::*;
#(parameter int unsigned DEPTH = 4) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [7:0]               in_a,
  input  logic [7:0]               in_b,
  output logic                     cy_start,
  output logic [7:0]               cy_a,
  output logic [7:0]               cy_b,
  input  logic                     cy_ready,
  input  logic [7:0]               cy_y,
  output logic                     res_valid,
  output logic [7:0]               res_y,
  output logic [7:0]               res_a,
  output logic [7:0]               res_b,
  output logic [15:0]              res_cycles,
  input  logic                     res_ack,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW      = $clog2(DEPTH);
  localparam int unsigned CW      = $clog2(DEPTH) + 1;
  localparam logic [15:0] CYC_MAX = 16'hFFFF;

  // Reject depths the pointer arithmetic cannot wrap correctly.
  if ((DEPTH < 2) || (DEPTH > 16) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
    $error("operand_feeder: DEPTH must be a power of two in 2..16");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_t;

  // FIFO storage and bookkeeping
  pair_t          mem_q [DEPTH];
  logic [PW-1:0]  wptr_q;
  logic [PW-1:0]  wptr_d;
  logic [PW-1:0]  rptr_q;
  logic [PW-1:0]  rptr_d;
  logic [CW-1:0]  count_q;
  logic [CW-1:0]  count_d;
  pair_t          head_c;
  pair_t          wr_pair_c;
  logic           push_c;
  logic           pop_c;

  // Sequencer state and registered outputs
  state_t         state_q;
  logic           cy_start_q;
  logic [7:0]     cy_a_q;
  logic [7:0]     cy_b_q;
  logic [15:0]    cyc_q;
  logic [15:0]    cyc_inc_c;
  logic           res_valid_q;
  logic [7:0]     res_y_q;
  logic [7:0]     res_a_q;
  logic [7:0]     res_b_q;
  logic [15:0]    res_cycles_q;

  // Handshake decode; a pop only ever sees the registered occupancy, so an
  // entry being pushed this cycle cannot be popped in the same cycle.
  always_comb begin
    in_ready  = (count_q < CW'(DEPTH));
    push_c    = in_valid && in_ready;
    pop_c     = (state_q == IDLE) && (count_q != '0) && !res_valid_q;
    head_c    = mem_q[rptr_q];
    wr_pair_c = '{a: in_a, b: in_b};
  end

  // Next pointer and occupancy values; simultaneous push and pop cancel out.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push_c) begin
      wptr_d = wptr_q + PW'(1);
    end
    if (pop_c) begin
      rptr_d = rptr_q + PW'(1);
    end
    unique case ({push_c, pop_c})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO payload storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem_q[wptr_q] <= wr_pair_c;
    end
  end

  // FIFO pointers and occupancy; reset empties the queue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Job latency counter increment, sticking at all-ones.
  always_comb begin
    cyc_inc_c = (cyc_q == CYC_MAX) ? cyc_q : (cyc_q + 16'd1);
  end

  // Job sequencer: issue head pair, wait for result, wait for engine idle,
  // then hold the result until acknowledged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cy_start_q   <= 1'b0;
      cy_a_q       <= '0;
      cy_b_q       <= '0;
      cyc_q        <= '0;
      res_valid_q  <= 1'b0;
      res_y_q      <= '0;
      res_a_q      <= '0;
      res_b_q      <= '0;
      res_cycles_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (pop_c) begin
            cy_a_q     <= head_c.a;
            cy_b_q     <= head_c.b;
            cy_start_q <= 1'b1;
            cyc_q      <= '0;
            state_q    <= ISSUE;
          end
        end
        ISSUE: begin
          cyc_q <= cyc_inc_c;
          if (cy_ready) begin
            res_y_q      <= cy_y;
            res_a_q      <= cy_a_q;
            res_b_q      <= cy_b_q;
            res_cycles_q <= cyc_inc_c;
            cy_start_q   <= 1'b0;
            state_q      <= DRAIN;
          end
        end
        DRAIN: begin
          if (!cy_ready) begin
            res_valid_q <= 1'b1;
            state_q     <= HOLD;
          end
        end
        HOLD: begin
          if (res_ack) begin
            res_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Output drive from registered state.
  always_comb begin
    cy_start   = cy_start_q;
    cy_a       = cy_a_q;
    cy_b       = cy_b_q;
    res_valid  = res_valid_q;
    res_y      = res_y_q;
    res_a      = res_a_q;
    res_b      = res_b_q;
    res_cycles = res_cycles_q;
    count      = count_q;
  end

endmodule

// File: tb/tb_operand_feeder.sv
// Self-checking bench for operand_feeder: behavioural engine model, driver
// tasks feeding a scoreboard queue, and a result monitor popping it.

module tb_operand_feeder;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    in_a;
  logic [7:0]    in_b;
  logic          cy_start;
  logic [7:0]    cy_a;
  logic [7:0]    cy_b;
  logic          cy_ready = 1'b0;
  logic [7:0]    cy_y = 8'd0;
  logic          res_valid;
  logic [7:0]    res_y;
  logic [7:0]    res_a;
  logic [7:0]    res_b;
  logic [15:0]   res_cycles;
  logic          res_ack;
  logic [CW-1:0] count;

  operand_feeder #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .cy_start   (cy_start),
    .cy_a       (cy_a),
    .cy_b       (cy_b),
    .cy_ready   (cy_ready),
    .cy_y       (cy_y),
    .res_valid  (res_valid),
    .res_y      (res_y),
    .res_a      (res_a),
    .res_b      (res_b),
    .res_cycles (res_cycles),
    .res_ack    (res_ack),
    .count      (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] y;
  } vec_t;

  typedef struct {
    logic [7:0] y;
    logic [7:0] a;
    logic [7:0] b;
  } exp_t;

  exp_t sb[$];
  int   checks     = 0;
  int   errors     = 0;
  int   eng_lat    = 1;
  int   n_results  = 0;
  bit   seen_valid = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // y = a^2 + floor(cbrt(b)), wrapped to 8 bits
  function automatic logic [7:0] ref_y(input logic [7:0] a, input logic [7:0] b);
    int r;
    int ia;
    r  = 0;
    ia = int'(a);
    while ((r + 1) * (r + 1) * (r + 1) <= int'(b)) r++;
    return 8'(ia * ia + r);
  endfunction

  // Engine model: latches operands on start, raises ready after eng_lat+1
  // cycles, drops it once start has fallen; checks operand stability.
  logic [7:0] e_a;
  logic [7:0] e_b;
  bit         e_busy = 1'b0;
  bit         e_done = 1'b0;
  int         e_cnt  = 0;

  always @(negedge clk) begin
    if (rst) begin
      cy_ready = 1'b0;
      e_busy   = 1'b0;
      e_done   = 1'b0;
      e_cnt    = 0;
    end else if (!e_busy && !e_done && cy_start) begin
      e_busy = 1'b1;
      e_cnt  = eng_lat;
      e_a    = cy_a;
      e_b    = cy_b;
    end else if (e_busy) begin
      check("cy_a_stable", int'(cy_a), int'(e_a));
      check("cy_b_stable", int'(cy_b), int'(e_b));
      if (e_cnt == 0) begin
        cy_y     = ref_y(e_a, e_b);
        cy_ready = 1'b1;
        e_busy   = 1'b0;
        e_done   = 1'b1;
      end else begin
        e_cnt--;
      end
    end else if (e_done) begin
      if (!cy_start) begin
        cy_ready = 1'b0;
        e_done   = 1'b0;
      end
    end
  end

  // Result monitor: a result is consumed when res_valid and res_ack are both
  // high ahead of the next rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      check("count_bound", int'(count <= CW'(DEPTH)), 1);
      if (res_valid) seen_valid = 1'b1;
      if (res_valid && res_ack) begin
        n_results++;
        if (sb.size() == 0) begin
          check("unexpected_result", int'(res_y), -1);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("res_y", int'(res_y), int'(e.y));
          check("res_a", int'(res_a), int'(e.a));
          check("res_b", int'(res_b), int'(e.b));
          check("res_cycles", int'(res_cycles), eng_lat + 2);
        end
      end
    end
  end

  // Offer one pair (entered just after a rising edge); records the accept.
  task automatic push_pair(input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] y, output int waits);
    exp_t e;
    waits    = 0;
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        e = '{y: y, a: a, b: b};
        sb.push_back(e);
        @(posedge clk);
        #1;
        break;
      end
      waits++;
      if (waits > 400) begin
        check("push_timeout", waits, 0);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  // Wait until every expected result has been taken and the block is idle.
  task automatic wait_drain(input string name);
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (sb.size() == 0 && !res_valid && count == '0 && !cy_start && !cy_ready) break;
      n++;
      if (n > 2000) begin
        check({name, "_drain_timeout"}, sb.size(), 0);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[7];

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int n;
    int base;
    bit push_done;

    vecs[0] = '{a: 8'd2,   b: 8'd27,  y: 8'd7};
    vecs[1] = '{a: 8'd0,   b: 8'd0,   y: 8'd0};
    vecs[2] = '{a: 8'd255, b: 8'd255, y: 8'd7};
    vecs[3] = '{a: 8'd16,  b: 8'd64,  y: 8'd4};
    vecs[4] = '{a: 8'd10,  b: 8'd125, y: 8'd105};
    vecs[5] = '{a: 8'd200, b: 8'd1,   y: 8'd65};
    vecs[6] = '{a: 8'd1,   b: 8'd1,   y: 8'd2};

    in_valid = 1'b0;
    in_a     = 8'd0;
    in_b     = 8'd0;
    res_ack  = 1'b0;
    rst      = 1'b0;
    #1 rst   = 1'b1;
    #1;
    // asynchronous reset values, before any clock edge
    check("rst_count",      int'(count),      0);
    check("rst_in_ready",   int'(in_ready),   1);
    check("rst_cy_start",   int'(cy_start),   0);
    check("rst_cy_a",       int'(cy_a),       0);
    check("rst_cy_b",       int'(cy_b),       0);
    check("rst_res_valid",  int'(res_valid),  0);
    check("rst_res_y",      int'(res_y),      0);
    check("rst_res_a",      int'(res_a),      0);
    check("rst_res_b",      int'(res_b),      0);
    check("rst_res_cycles", int'(res_cycles), 0);

    // first push right after release, single job (3,8) -> 11
    @(posedge clk);
    #1;
    rst     = 1'b0;
    res_ack = 1'b1;
    eng_lat = 1;
    push_pair(8'd3, 8'd8, 8'd11, w);
    check("first_push_wait", w, 0);
    wait_drain("single");
    check("single_result_count", n_results, 1);

    // table vectors back-to-back at two engine latencies
    for (int pass = 0; pass < 2; pass++) begin
      eng_lat = (pass == 0) ? 0 : 3;
      base    = n_results;
      for (int i = 0; i < 7; i++) begin
        push_pair(vecs[i].a, vecs[i].b, vecs[i].y, w);
      end
      wait_drain("table");
      check("table_result_count", n_results - base, 7);
    end

    // backpressure: consumer stalled, six pairs offered from empty
    eng_lat = 1;
    res_ack = 1'b0;
    base    = n_results;
    for (int i = 0; i < 5; i++) begin
      push_pair(8'(i + 1), 8'(i + 1), ref_y(8'(i + 1), 8'(i + 1)), w);
      check("fill_push_wait", w, 0);
    end
    in_a     = 8'd6;
    in_b     = 8'd6;
    in_valid = 1'b1;
    n = 0;
    while (!res_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("stall_result_held", int'(res_valid), 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_in_ready", int'(in_ready), 0);
      check("stall_count", int'(count), 4);
    end
    @(posedge clk);
    #1;
    res_ack = 1'b1;
    push_pair(8'd6, 8'd6, 8'd37, w);
    check("stall_sixth_waited", int'(w > 0), 1);
    wait_drain("stall");
    check("stall_result_count", n_results - base, 6);

    // 3*DEPTH pairs with random consumer gaps, crossing pointer wrap
    base      = n_results;
    push_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 3 * DEPTH; i++) begin
          repeat ($urandom_range(0, 2)) @(posedge clk);
          #1;
          push_pair(8'(i), 8'(i), ref_y(8'(i), 8'(i)), w);
        end
        push_done = 1'b1;
      end
      begin
        int cyc;
        cyc = 0;
        while (!(push_done && sb.size() == 0) && cyc < 3000) begin
          @(posedge clk);
          #1;
          res_ack = 1'($urandom_range(0, 1));
          cyc++;
        end
      end
    join
    res_ack = 1'b1;
    wait_drain("random");
    check("random_result_count", n_results - base, 3 * DEPTH);

    // reset mid-job: (5,1) in the engine, two pairs queued
    eng_lat = 20;
    push_pair(8'd5, 8'd1, ref_y(8'd5, 8'd1), w);
    push_pair(8'd7, 8'd7, ref_y(8'd7, 8'd7), w);
    push_pair(8'd9, 8'd9, ref_y(8'd9, 8'd9), w);
    check("midjob_cy_start", int'(cy_start), 1);
    check("midjob_count", int'(count), 2);
    check("midjob_cy_a", int'(cy_a), 5);
    #3 rst = 1'b1;
    #1;
    check("arst_cy_start", int'(cy_start), 0);
    check("arst_count", int'(count), 0);
    check("arst_res_valid", int'(res_valid), 0);
    check("arst_in_ready", int'(in_ready), 1);
    sb.delete();
    @(posedge clk);
    #1;
    rst        = 1'b0;
    seen_valid = 1'b0;
    base       = n_results;
    repeat (40) @(negedge clk);
    check("post_rst_no_result", int'(seen_valid), 0);
    check("post_rst_cy_start", int'(cy_start), 0);
    check("post_rst_count", int'(count), 0);
    check("post_rst_result_count", n_results - base, 0);

    // stray ack while idle and empty
    @(posedge clk);
    #1;
    res_ack = 1'b0;
    @(posedge clk);
    #1;
    res_ack = 1'b1;
    @(posedge clk);
    #1;
    res_ack = 1'b0;
    @(negedge clk);
    check("stray_ack_res_valid", int'(res_valid), 0);
    check("stray_ack_cy_start", int'(cy_start), 0);
    check("stray_ack_count", int'(count), 0);
    check("stray_ack_in_ready", int'(in_ready), 1);

    // block still works after the mid-job reset
    @(posedge clk);
    #1;
    eng_lat = 2;
    res_ack = 1'b1;
    base    = n_results;
    push_pair(8'd4, 8'd8, 8'd18, w);
    wait_drain("after_rst");
    check("after_rst_result_count", n_results - base, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
